// File: rtl/decoder_scan_nto2n.sv
// decoder_scan_nto2n: registered N-to-2^N active-low decoder with a timed
// scan mode that walks a single low output across every line, holding each
// line for DWELL cycles. All outputs come straight from flops.
module decoder_scan_nto2n #(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter bit CONT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    sel,
  input  logic            start,
  output logic [2**N-1:0] y_n,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    idx
);

  localparam int M  = 2 ** N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST = N'(M - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [N-1:0]    idx_next;
  logic [M-1:0]    y_next;
  logic            busy_next, done_next;
  logic            sweep_end;

  // Last dwell cycle of the last line: the sweep completes on this edge.
  assign sweep_end = (state == S_SCAN) && (idx == IDX_LAST) && (cnt == CNT_LAST);

  // State and output registers; reset drives every output to its idle value.
  // NOTE: non-blocking assignments keep all flops updating from the same
  // pre-edge values, which is what makes y_n and idx move in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      y_n   <= '1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      y_n   <= y_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state: enter SCAN on an enabled start in scan mode; leave on abort
  // or at the end of a single sweep.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (en && mode && start) state_next = S_SCAN;
      S_SCAN: begin
        if (!en)                           state_next = S_IDLE;
        else if (sweep_end && CONT == 1'b0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Next register values for the outputs and the dwell counter.
  // NOTE: every target gets a default before the case, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    cnt_next  = '0;
    idx_next  = '0;
    y_next    = '1;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (!mode) begin
          if (en) y_next = ~(M'(1) << sel);
        end else if (en && start) begin
          busy_next = 1'b1;
          y_next    = ~M'(1);
        end
      end
      S_SCAN: begin
        if (en) begin
          busy_next = 1'b1;
          if (cnt != CNT_LAST) begin
            cnt_next = cnt + CW'(1);
            idx_next = idx;
          end else begin
            // idx wraps from 2^N-1 to 0 naturally in N bits.
            idx_next = idx + N'(1);
          end
          if (sweep_end) begin
            done_next = 1'b1;
            if (CONT == 1'b0) begin
              busy_next = 1'b0;
              idx_next  = '0;
            end
          end
          if (sweep_end && CONT == 1'b0) y_next = '1;
          else                           y_next = ~(M'(1) << idx_next);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Testbench for decoder_scan_nto2n: three instances (single sweep, continuous,
// longer dwell) share one stimulus stream and are compared every cycle against
// a model that derives the expected outputs from the time elapsed since start.
module tb_decoder_scan_nto2n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;
  logic       start = 1'b0;

  logic [7:0] y_a;  logic busy_a, done_a;  logic [2:0] idx_a;
  logic [3:0] y_b;  logic busy_b, done_b;  logic [1:0] idx_b;
  logic [7:0] y_c;  logic busy_c, done_c;  logic [2:0] idx_c;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  typedef struct {
    bit scanning;
    int t0;
  } mstate_t;

  mstate_t    ms_a, ms_b, ms_c;
  logic [63:0] exp_a, exp_b, exp_c;

  always #5 clk = ~clk;

  decoder_scan_nto2n #(.N(3), .DWELL(2), .CONT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .y_n(y_a), .busy(busy_a), .done(done_a), .idx(idx_a));

  decoder_scan_nto2n #(.N(2), .DWELL(1), .CONT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .start(start),
    .y_n(y_b), .busy(busy_b), .done(done_b), .idx(idx_b));

  decoder_scan_nto2n #(.N(3), .DWELL(3), .CONT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .y_n(y_c), .busy(busy_c), .done(done_c), .idx(idx_c));

  function automatic logic [63:0] pack(input logic [63:0] y, input logic b,
                                       input logic d, input logic [63:0] i);
    return {y[53:0], b, d, i[7:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs after the current edge, from the rules: a sweep lasts
  // 2^n*dwell edges, line = (edges since start mod sweep) / dwell.
  task automatic model_step(input int n, input int dwell, input bit cont,
                            inout mstate_t s, output logic [63:0] exp);
    int ones, sl, k, line, s_sel;
    ones  = (1 << (1 << n)) - 1;
    sl    = (1 << n) * dwell;
    s_sel = int'(sel) & ((1 << n) - 1);
    if (!s.scanning) begin
      if (en && mode && start) begin
        s.scanning = 1'b1;
        s.t0 = edge_cnt;
        exp = pack(64'(ones & ~1), 1'b1, 1'b0, 64'd0);
      end else begin
        exp = pack(64'((en && !mode) ? (ones & ~(1 << s_sel)) : ones), 1'b0, 1'b0, 64'd0);
      end
    end else if (!en) begin
      s.scanning = 1'b0;
      exp = pack(64'(ones), 1'b0, 1'b0, 64'd0);
    end else begin
      k = edge_cnt - s.t0;
      if (!cont && k == sl) begin
        s.scanning = 1'b0;
        exp = pack(64'(ones), 1'b0, 1'b1, 64'd0);
      end else begin
        line = (k % sl) / dwell;
        exp = pack(64'(ones & ~(1 << line)), 1'b1, (k % sl) == 0, 64'(line));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    model_step(3, 2, 1'b0, ms_a, exp_a);
    model_step(2, 1, 1'b1, ms_b, exp_b);
    model_step(3, 3, 1'b0, ms_c, exp_c);
    @(negedge clk);
    check("dut_a", pack(64'(y_a), busy_a, done_a, 64'(idx_a)), exp_a);
    check("dut_b", pack(64'(y_b), busy_b, done_b, 64'(idx_b)), exp_b);
    check("dut_c", pack(64'(y_c), busy_c, done_c, 64'(idx_c)), exp_c);
  endtask

  task automatic reset_models();
    ms_a = '{scanning: 1'b0, t0: 0};
    ms_b = '{scanning: 1'b0, t0: 0};
    ms_c = '{scanning: 1'b0, t0: 0};
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a"}, pack(64'(y_a), busy_a, done_a, 64'(idx_a)), pack(64'hFF, 1'b0, 1'b0, 64'd0));
    check({tag, "_b"}, pack(64'(y_b), busy_b, done_b, 64'(idx_b)), pack(64'hF,  1'b0, 1'b0, 64'd0));
    check({tag, "_c"}, pack(64'(y_c), busy_c, done_c, 64'(idx_c)), pack(64'hFF, 1'b0, 1'b0, 64'd0));
  endtask

  logic [7:0] direct_tbl [8];

  initial begin
    direct_tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    reset_models();

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;

    // Direct decode, one-cycle latency.
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      check("direct_tbl", 64'(y_a), 64'(direct_tbl[i]));
    end
    en = 1'b0;
    tick();
    check("direct_en0", 64'(y_a), 64'hFF);

    // Start with mode=0 is ignored.
    en = 1'b1; start = 1'b1; sel = 3'd5;
    tick();
    start = 1'b0;
    tick();

    // Single sweep on A and C, continuous on B; a second start while busy
    // and mode/sel churn must not disturb timing.
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 4);
      sel   = 3'($urandom);
      mode  = (i < 14) ? 1'($urandom) : 1'b1;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Abort during line 2 of C (dwell 3).
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Asynchronous reset in the middle of a scan.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    reset_models();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom % 40) != 0;
      mode  = ($urandom % 8) != 0;
      start = ($urandom % 6) == 0;
      sel   = 3'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
